// File: rtl/resp_router.sv
// resp_router: in-order response router.
// Every issued request leaves a {slave index, address-found} entry in a small
// tracker FIFO. The entry at the head decides where the next master response
// comes from: the indexed slave, or a locally generated decode error when the
// request missed the address map or names a slave that does not exist.
// Optional feature: define RESP_ROUTER_ERR_COUNT_EN to count locally generated
// decode-error responses on err_count_o (saturating). Without it err_count_o
// is tied to zero.
module resp_router #(
    parameter int NUM_SLV         = 4,
    parameter int SLV_INDEX_WIDTH = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [SLV_INDEX_WIDTH-1:0]            req_slave_index_i,
    input  logic                                  req_addr_found_i,
    input  logic [NUM_SLV-1:0]                    slv_rsp_valid_i,
    input  logic [NUM_SLV-1:0][DATA_WIDTH-1:0]    slv_rsp_data_i,
    input  logic [NUM_SLV-1:0]                    slv_rsp_err_i,
    output logic [NUM_SLV-1:0]                    slv_rsp_ready_o,
    output logic                                  mst_rsp_valid_o,
    output logic [DATA_WIDTH-1:0]                 mst_rsp_data_o,
    output logic                                  mst_rsp_err_o,
    input  logic                                  mst_rsp_ready_i,
    output logic [$clog2(MAX_OUTSTANDING):0]      outstanding_o,
    output logic [15:0]                           err_count_o
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [SLV_INDEX_WIDTH:0] NUM_SLV_W = (SLV_INDEX_WIDTH + 1)'(NUM_SLV);

    // Tracker storage: one index and one found flag per outstanding request.
    // The storage itself is not reset; validity is carried by the count.
    logic [SLV_INDEX_WIDTH-1:0] idx_mem   [MAX_OUTSTANDING];
    logic                       found_mem [MAX_OUTSTANDING];

    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;

    logic                       push;
    logic                       pop;
    logic                       empty;
    logic [SLV_INDEX_WIDTH-1:0] head_idx;
    logic                       head_found;
    logic                       head_routed;

    // Full/empty come from the occupancy count, so the pointers may wrap freely.
    assign empty       = (count == '0);
    assign req_ready_o = (count != FULL_CNT);
    assign push        = req_valid_i && req_ready_o;
    assign pop         = mst_rsp_valid_o && mst_rsp_ready_i;

    assign head_idx    = idx_mem[rd_ptr];
    assign head_found  = found_mem[rd_ptr];

    // A head entry is routed to a real slave only when the address hit a rule
    // and the index names one of the NUM_SLV ports; otherwise it is a decode error.
    assign head_routed = head_found && ({1'b0, head_idx} < NUM_SLV_W);

    assign outstanding_o = count;

    // Capture the request's routing information at the write pointer on a push.
    always_ff @(posedge clk_i) begin
        if (push) begin
            idx_mem[wr_ptr]   <= req_slave_index_i;
            found_mem[wr_ptr] <= req_addr_found_i;
        end
    end

    // Pointer and occupancy bookkeeping; a push and a pop together leave the count alone.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Zero-latency response steering from the head slave, or a local decode error.
    always_comb begin
        mst_rsp_valid_o = 1'b0;
        mst_rsp_data_o  = '0;
        mst_rsp_err_o   = 1'b0;
        slv_rsp_ready_o = '0;
        if (!empty) begin
            if (head_routed) begin
                for (int i = 0; i < NUM_SLV; i++) begin
                    if (head_idx == SLV_INDEX_WIDTH'(i)) begin
                        mst_rsp_valid_o    = slv_rsp_valid_i[i];
                        mst_rsp_data_o     = slv_rsp_data_i[i];
                        mst_rsp_err_o      = slv_rsp_err_i[i];
                        slv_rsp_ready_o[i] = mst_rsp_ready_i;
                    end
                end
            end else begin
                mst_rsp_valid_o = 1'b1;
                mst_rsp_data_o  = '0;
                mst_rsp_err_o   = 1'b1;
            end
        end
    end

`ifdef RESP_ROUTER_ERR_COUNT_EN
    logic [15:0] err_count;
    logic        err_pop;

    assign err_pop = pop && !head_routed;

    // Saturating count of decode-error responses handed to the master.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_count <= '0;
        end else if (err_pop && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

    assign err_count_o = err_count;
`else
    assign err_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_resp_router.sv
// tb_resp_router: self-checking bench for resp_router.
// A queue of {index, found} entries models the tracker; expected master and
// slave-side outputs are derived from the head of that queue every cycle.
// Build with RESP_ROUTER_ERR_COUNT_EN defined to also expect the error counter.
module tb_resp_router;

    localparam int NUM_SLV = 4;
    localparam int IW      = 2;
    localparam int DW      = 32;
    localparam int MAXO    = 8;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic          found;
    } entry_t;

    logic                        clk = 1'b0;
    logic                        rstN;
    logic                        reqValid;
    logic                        reqReady;
    logic [IW-1:0]               reqIdx;
    logic                        reqFound;
    logic [NUM_SLV-1:0]          slvValid;
    logic [NUM_SLV-1:0][DW-1:0]  slvData;
    logic [NUM_SLV-1:0]          slvErr;
    logic [NUM_SLV-1:0]          slvReady;
    logic                        mstValid;
    logic [DW-1:0]               mstData;
    logic                        mstErr;
    logic                        mstReady;
    logic [3:0]                  outstanding;
    logic [15:0]                 errCount;

    entry_t q[$];
    int     errModel;
    int     nChecks;
    int     nFails;
    int     nPush;
    int     nPop;
    bit     randSlaves;

    resp_router #(
        .NUM_SLV(NUM_SLV),
        .SLV_INDEX_WIDTH(IW),
        .DATA_WIDTH(DW),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk),
        .rst_ni(rstN),
        .req_valid_i(reqValid),
        .req_ready_o(reqReady),
        .req_slave_index_i(reqIdx),
        .req_addr_found_i(reqFound),
        .slv_rsp_valid_i(slvValid),
        .slv_rsp_data_i(slvData),
        .slv_rsp_err_i(slvErr),
        .slv_rsp_ready_o(slvReady),
        .mst_rsp_valid_o(mstValid),
        .mst_rsp_data_o(mstData),
        .mst_rsp_err_o(mstErr),
        .mst_rsp_ready_i(mstReady),
        .outstanding_o(outstanding),
        .err_count_o(errCount)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Absolute time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input logic rv, input logic [IW-1:0] idx, input logic found, input logic mr);
        logic               expReady;
        logic               expValid;
        logic               expErr;
        logic [DW-1:0]      expData;
        logic [NUM_SLV-1:0] expSlvReady;
        logic               doPush;
        logic               doPop;
        logic               headIsErr;
        int                 hs;
        entry_t             head;
        entry_t             nw;

        reqValid = rv;
        reqIdx   = idx;
        reqFound = found;
        mstReady = mr;
        if (randSlaves) begin
            for (int s = 0; s < NUM_SLV; s++) begin
                if (!slvValid[s] && ($urandom_range(1, 0) == 1)) begin
                    slvValid[s] = 1'b1;
                    slvData[s]  = $urandom;
                    slvErr[s]   = ($urandom_range(3, 0) == 0);
                end
            end
        end
        #4;

        expReady    = (q.size() < MAXO);
        expValid    = 1'b0;
        expErr      = 1'b0;
        expData     = '0;
        expSlvReady = '0;
        headIsErr   = 1'b0;
        hs          = -1;
        head        = '0;
        if (q.size() > 0) begin
            head = q[0];
            if (head.found && (int'(head.idx) < NUM_SLV)) begin
                expValid              = slvValid[head.idx];
                expData               = slvData[head.idx];
                expErr                = slvErr[head.idx];
                expSlvReady[head.idx] = mr;
                if (slvValid[head.idx] && mr) begin
                    hs = int'(head.idx);
                end
            end else begin
                headIsErr = 1'b1;
                expValid  = 1'b1;
                expErr    = 1'b1;
            end
        end

        checkOutput("req_ready", 64'(reqReady), 64'(expReady));
        checkOutput("mst_valid", 64'(mstValid), 64'(expValid));
        checkOutput("slv_ready", 64'(slvReady), 64'(expSlvReady));
        checkOutput("outstanding", 64'(outstanding), 64'(q.size()));
        checkOutput("err_count", 64'(errCount), 64'(errModel));
        if (expValid) begin
            checkOutput("mst_data", 64'(mstData), 64'(expData));
            checkOutput("mst_err", 64'(mstErr), 64'(expErr));
        end

        doPush = rv && expReady;
        doPop  = expValid && mr;

        @(posedge clk);
        #1;

        if (doPop) begin
            void'(q.pop_front());
            nPop++;
`ifdef RESP_ROUTER_ERR_COUNT_EN
            if (headIsErr && (errModel < 65535)) begin
                errModel++;
            end
`endif
        end
        if (doPush) begin
            nw.idx   = idx;
            nw.found = found;
            q.push_back(nw);
            nPush++;
        end
        if (hs >= 0) begin
            slvValid[hs] = 1'b0;
        end
    endtask

    // Hold reset low for n edges and clear the model.
    task automatic doReset(input int n);
        rstN = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rstN     = 1'b1;
        q.delete();
        errModel = 0;
    endtask

    // Let random slaves answer everything outstanding, within a cycle budget.
    task automatic drainAll(input string tag);
        int n;
        n          = 0;
        randSlaves = 1'b1;
        while ((q.size() != 0) && (n < 500)) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        if (q.size() != 0) begin
            checkOutput({tag, "_timeout"}, 64'(q.size()), 64'd0);
        end
        checkOutput({tag, "_outstanding"}, 64'(outstanding), 64'd0);
        randSlaves = 1'b0;
        slvValid   = '0;
    endtask

    initial begin
        nChecks    = 0;
        nFails     = 0;
        nPush      = 0;
        nPop       = 0;
        errModel   = 0;
        randSlaves = 1'b0;
        rstN       = 1'b0;
        reqValid   = 1'b0;
        reqIdx     = '0;
        reqFound   = 1'b0;
        mstReady   = 1'b0;
        slvValid   = '0;
        slvData    = '0;
        slvErr     = '0;
        @(posedge clk);
        #1;
        doReset(2);

        // Post-reset idle state.
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Single routed response from slave 2.
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b1);
        slvValid[2] = 1'b1;
        slvData[2]  = 32'hCAFE0001;
        slvErr[2]   = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Decode error for an unmapped address.
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // In-order routing: slave 0 answers first but must wait behind slave 1.
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
        slvValid[0] = 1'b1;
        slvData[0]  = 32'hA0A0_0000;
        slvErr[0]   = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        slvValid[1] = 1'b1;
        slvData[1]  = 32'hB1B1_1111;
        slvErr[1]   = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        // Fill the tracker, then try a push while a pop happens.
        for (int i = 0; i < MAXO; i++) begin
            applyStimulus(1'b1, IW'(i % NUM_SLV), 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
        slvValid[0] = 1'b1;
        slvData[0]  = 32'h0000_F00D;
        slvErr[0]   = 1'b0;
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        drainAll("full_drain");

        // Random traffic with wrapping pointers.
        nPush = 0;
        nPop  = 0;
        randSlaves = 1'b1;
        for (int cyc = 0; (cyc < 2000) && ((nPush < 20) || (nPop < 20)); cyc++) begin
            applyStimulus(1'($urandom_range(1, 0)), IW'($urandom_range(NUM_SLV - 1, 0)),
                          1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)));
        end
        checkOutput("random_pushes", 64'(nPush >= 20), 64'd1);
        drainAll("random_drain");

        // Reset with three entries in flight.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, IW'(i), 1'b1, 1'b0);
        end
        doReset(1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 2'd3, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
